// File: rtl/qp_param_demux_bank.sv
// Double-buffered parameter demux: host words go through a one-deep stage into a
// shadow bank, and a commit copies the whole shadow bank to the active output lines.
module qp_param_demux_bank #(
    parameter int DATA_W    = 32,
    parameter int N_CH      = 24,
    parameter int ADDR_W    = 7,
    parameter int BASE_ADDR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     burst_start,
    input  logic [ADDR_W-1:0]        burst_len,
    input  logic                     commit,
    output logic [N_CH*DATA_W-1:0]   lines_flat,
    output logic                     all_loaded,
    output logic                     addr_err,
    output logic                     commit_done
);
    typedef enum logic [1:0] {IDLE, BURST, COMMIT} state_t;

    localparam logic [ADDR_W-1:0] ADDR_LO   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BASE_ADDR + N_CH - 1);
    localparam logic [ADDR_W:0]   ADDR_END  = (ADDR_W+1)'(BASE_ADDR + N_CH);

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   cnt;
    logic                commit_pend;
    logic                stage_vld;
    logic [ADDR_W-1:0]   stage_addr;
    logic [DATA_W-1:0]   stage_data;
    logic [DATA_W-1:0]   shadow [N_CH];
    logic [DATA_W-1:0]   active [N_CH];
    logic [N_CH-1:0]     mask;

    logic                accept;
    logic                copy_now;
    logic                stage_in_range;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   stage_idx;
    logic [ADDR_W-1:0]   len_eff;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == ADDR_LAST) ? ADDR_LO : p + ADDR_W'(1);
    endfunction

    assign wr_ready       = !rst && (state != COMMIT);
    assign accept         = wr_valid && wr_ready;
    assign target         = (state == BURST) ? ptr : wr_addr;
    assign len_eff        = (burst_len == '0) ? ADDR_W'(1) : burst_len;
    assign stage_in_range = (stage_addr >= ADDR_LO) && ({1'b0, stage_addr} < ADDR_END);
    assign stage_idx      = stage_addr - ADDR_LO;
    // The copy waits for the stage to drain so a write accepted with commit still lands.
    assign copy_now       = (state == COMMIT) && !stage_vld;

    // NOTE: always_comb outputs get a default first so no latch is inferred.
    always_comb begin
        lines_flat = '0;
        for (int k = 0; k < N_CH; k++) begin
            lines_flat[k*DATA_W +: DATA_W] = active[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld  <= 1'b0;
            stage_addr <= '0;
            stage_data <= '0;
        end else begin
            stage_vld <= accept;
            if (accept) begin
                stage_addr <= target;
                stage_data <= wr_data;
            end
        end
    end

    // NOTE: both banks are flops and are cleared on reset, so the core never sees stale parameters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            mask       <= '0;
            addr_err   <= 1'b0;
            all_loaded <= 1'b0;
        end else begin
            all_loaded <= &mask;
            if (stage_vld) begin
                if (stage_in_range) begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (stage_idx == ADDR_W'(k)) begin
                            shadow[k] <= stage_data;
                            mask[k]   <= 1'b1;
                        end
                    end
                end else begin
                    addr_err <= 1'b1;
                end
            end
            if (copy_now) begin
                for (int k = 0; k < N_CH; k++) begin
                    active[k] <= shadow[k];
                end
                mask <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            commit_pend <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (burst_start) begin
                        // A word arriving with burst_start is the first burst word.
                        if (accept) begin
                            ptr <= next_ptr(wr_addr);
                            cnt <= len_eff - ADDR_W'(1);
                            if (len_eff == ADDR_W'(1)) begin
                                state <= commit ? COMMIT : IDLE;
                            end else begin
                                state       <= BURST;
                                commit_pend <= commit;
                            end
                        end else begin
                            ptr         <= wr_addr;
                            cnt         <= len_eff;
                            state       <= BURST;
                            commit_pend <= commit;
                        end
                    end else if (commit) begin
                        state <= COMMIT;
                    end
                end
                BURST: begin
                    if (commit) commit_pend <= 1'b1;
                    if (accept) begin
                        ptr <= next_ptr(ptr);
                        cnt <= cnt - ADDR_W'(1);
                        if (cnt == ADDR_W'(1)) begin
                            state       <= (commit_pend || commit) ? COMMIT : IDLE;
                            commit_pend <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    if (!stage_vld) begin
                        state       <= IDLE;
                        commit_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qp_param_demux_bank.sv
// Directed bench for qp_param_demux_bank: single writes, bursts with wrap,
// range errors, commit timing and reset during commit.
module tb_qp_param_demux_bank;
    localparam int DATA_W = 32;
    localparam int N_CH   = 24;
    localparam int ADDR_W = 7;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   burst_start;
    logic [ADDR_W-1:0]      burst_len;
    logic                   commit;
    logic [N_CH*DATA_W-1:0] lines_flat;
    logic                   all_loaded;
    logic                   addr_err;
    logic                   commit_done;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] exp_bank [N_CH];

    always #5 clk = ~clk;

    qp_param_demux_bank #(
        .DATA_W(DATA_W), .N_CH(N_CH), .ADDR_W(ADDR_W), .BASE_ADDR(1)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .burst_start(burst_start),
        .burst_len(burst_len), .commit(commit), .lines_flat(lines_flat),
        .all_loaded(all_loaded), .addr_err(addr_err), .commit_done(commit_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] ch(input int k);
        return lines_flat[k*DATA_W +: DATA_W];
    endfunction

    function automatic int bank_diffs();
        int n = 0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch(k) !== exp_bank[k]) n++;
        end
        return n;
    endfunction

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int waited = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (!wr_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!wr_ready) begin
            tests++;
            fails++;
            $display("FAIL write_timeout: wr_ready got %b, want 1 within 20 cycles", wr_ready);
        end
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_commit(output int pulses);
        commit = 1'b1;
        step();
        commit = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (commit_done) pulses++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        burst_start = 1'b0; burst_len = '0; commit = 1'b0;
        for (int k = 0; k < N_CH; k++) exp_bank[k] = '0;
        step();
        step();
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready: got %b, want 0", wr_ready); end
        tests++; if (lines_flat !== '0) begin fails++; $display("FAIL reset_lines: got %h, want 0", lines_flat); end
        tests++; if (all_loaded !== 1'b0) begin fails++; $display("FAIL reset_all_loaded: got %b, want 0", all_loaded); end
        tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL reset_addr_err: got %b, want 0", addr_err); end
        tests++; if (commit_done !== 1'b0) begin fails++; $display("FAIL reset_commit_done: got %b, want 0", commit_done); end
        rst = 1'b0;
        step();
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL post_reset_wr_ready: got %b, want 1", wr_ready); end
    endtask

    task automatic test_single();
        int pulses;
        write_word(7'd1, 32'h0000_0011);
        write_word(7'd24, 32'hFFFF_FFF0);
        step();
        step();
        tests++; if (lines_flat !== '0) begin fails++; $display("FAIL single_precommit_lines: got %h, want 0", lines_flat); end
        tests++; if (all_loaded !== 1'b0) begin fails++; $display("FAIL single_all_loaded: got %b, want 0", all_loaded); end
        exp_bank[0]  = 32'h0000_0011;
        exp_bank[23] = 32'hFFFF_FFF0;
        do_commit(pulses);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL single_commit_done_pulses: got %0d, want 1", pulses); end
        tests++; if (bank_diffs() !== 0) begin fails++; $display("FAIL single_bank: %0d channels differ, want 0", bank_diffs()); end
        tests++; if ($signed(ch(23)) !== -16) begin fails++; $display("FAIL single_ch23_signed: got %0d, want -16", $signed(ch(23))); end
    endtask

    task automatic test_burst_wrap();
        int pulses;
        wr_addr = 7'd20; burst_len = 7'd8; burst_start = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 32'(100 + i);
            step();
            burst_start = 1'b0;
        end
        wr_valid = 1'b0;
        // Back in IDLE this goes to addr 5 (ch 4); a stuck burst would send it to ch 3.
        write_word(7'd5, 32'h0000_0055);
        step();
        step();
        for (int i = 0; i < 5; i++) exp_bank[19+i] = 32'(100 + i);
        for (int i = 0; i < 3; i++) exp_bank[i] = 32'(105 + i);
        exp_bank[4] = 32'h0000_0055;
        do_commit(pulses);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL burst_commit_done_pulses: got %0d, want 1", pulses); end
        tests++; if (ch(0) !== 32'd105) begin fails++; $display("FAIL burst_wrap_ch0: got %0d, want 105", ch(0)); end
        tests++; if (bank_diffs() !== 0) begin fails++; $display("FAIL burst_bank: %0d channels differ, want 0", bank_diffs()); end
        tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL burst_addr_err: got %b, want 0", addr_err); end
    endtask

    task automatic test_full_load();
        int pulses;
        wr_addr = 7'd1; burst_len = 7'd24; burst_start = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            wr_data = 32'hA500_0000 + 32'(i);
            exp_bank[i] = 32'hA500_0000 + 32'(i);
            step();
            burst_start = 1'b0;
        end
        wr_valid = 1'b0;
        tests++; if (all_loaded !== 1'b0) begin fails++; $display("FAIL full_all_loaded_early0: got %b, want 0", all_loaded); end
        step();
        tests++; if (all_loaded !== 1'b0) begin fails++; $display("FAIL full_all_loaded_early1: got %b, want 0", all_loaded); end
        step();
        tests++; if (all_loaded !== 1'b1) begin fails++; $display("FAIL full_all_loaded: got %b, want 1", all_loaded); end
        do_commit(pulses);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL full_commit_done_pulses: got %0d, want 1", pulses); end
        tests++; if (all_loaded !== 1'b0) begin fails++; $display("FAIL full_all_loaded_cleared: got %b, want 0", all_loaded); end
        tests++; if (bank_diffs() !== 0) begin fails++; $display("FAIL full_bank: %0d channels differ, want 0", bank_diffs()); end
    endtask

    task automatic test_addr_err();
        int pulses;
        write_word(7'd25, 32'h0000_BEEF);
        step();
        step();
        tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL err_addr25: got %b, want 1", addr_err); end
        write_word(7'd0, 32'h0000_DEAD);
        step();
        step();
        tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b, want 1", addr_err); end
        // Back-to-back writes to one address: the later word wins.
        write_word(7'd10, 32'h1234_5678);
        write_word(7'd10, 32'h8765_4321);
        exp_bank[9] = 32'h8765_4321;
        // burst_len 0 acts as 1, so the next single write is a plain IDLE write.
        wr_addr = 7'd12; burst_len = 7'd0; burst_start = 1'b1; wr_valid = 1'b1; wr_data = 32'h0000_0C0C;
        step();
        burst_start = 1'b0; wr_valid = 1'b0;
        exp_bank[11] = 32'h0000_0C0C;
        write_word(7'd20, 32'h0000_2020);
        exp_bank[19] = 32'h0000_2020;
        step();
        step();
        do_commit(pulses);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL err_commit_done_pulses: got %0d, want 1", pulses); end
        tests++; if (bank_diffs() !== 0) begin fails++; $display("FAIL err_bank: %0d channels differ, want 0", bank_diffs()); end
        tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL err_sticky_after_commit: got %b, want 1", addr_err); end
    endtask

    task automatic test_commit_mid_burst();
        int pulses;
        wr_addr = 7'd3; burst_len = 7'd6; burst_start = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 32'(200 + i);
            commit  = (i == 3);
            step();
            burst_start = 1'b0;
            commit      = 1'b0;
        end
        wr_valid = 1'b0;
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL mid_wr_ready_commit: got %b, want 0", wr_ready); end
        tests++; if (bank_diffs() !== 0) begin fails++; $display("FAIL mid_early_copy: %0d channels differ, want 0", bank_diffs()); end
        for (int i = 0; i < 6; i++) exp_bank[2+i] = 32'(200 + i);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (commit_done) pulses++;
            step();
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL mid_commit_done_pulses: got %0d, want 1", pulses); end
        tests++; if (bank_diffs() !== 0) begin fails++; $display("FAIL mid_bank: %0d channels differ, want 0", bank_diffs()); end
    endtask

    task automatic test_reset_in_commit();
        int pulses;
        write_word(7'd15, 32'h0000_0777);
        commit = 1'b1;
        step();
        commit = 1'b0;
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL rstc_in_commit_wr_ready: got %b, want 0", wr_ready); end
        rst = 1'b1;
        step();
        tests++; if (lines_flat !== '0) begin fails++; $display("FAIL rstc_lines: got %h, want 0", lines_flat); end
        tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL rstc_addr_err: got %b, want 0", addr_err); end
        tests++; if (commit_done !== 1'b0) begin fails++; $display("FAIL rstc_commit_done: got %b, want 0", commit_done); end
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL rstc_wr_ready: got %b, want 0", wr_ready); end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (commit_done) pulses++;
            step();
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL rstc_no_commit_done: got %0d pulses, want 0", pulses); end
        tests++; if (lines_flat !== '0) begin fails++; $display("FAIL rstc_lines_after: got %h, want 0", lines_flat); end
        for (int k = 0; k < N_CH; k++) exp_bank[k] = '0;
        do_commit(pulses);
        tests++; if (bank_diffs() !== 0) begin fails++; $display("FAIL rstc_shadow_cleared: %0d channels differ, want 0", bank_diffs()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_wrap();
        test_full_load();
        test_addr_err();
        test_commit_mid_burst();
        test_reset_in_commit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end
endmodule

// File: doc/qp_param_demux_bank.md
Name: qp_param_demux_bank

Overview:
- Parametrised, double-buffered successor to the 24-way parameter demux feeding the LVI-PDNN solver's parameter lines.
- A host-side loader writes (address, data) words through a valid/ready port into a shadow register bank, either one word at a time or as auto-incrementing bursts.
- A commit copies the whole shadow bank to the active output lines in one cycle, so the PDNN core never sees a half-updated parameter set.
- Sits between the parameter-conversion stage and the network core.

Parameters:
DATA_W, 32, width of each parameter word (signed)
N_CH, 24, number of output channels
ADDR_W, 7, address bus width
BASE_ADDR, 1, address mapped to channel 0; channel k is at BASE_ADDR+k

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_valid  in  1  write word present
wr_ready  out  1  block can accept a word this cycle
wr_addr  in  ADDR_W  single-write address, or burst start address when burst_start=1
wr_data  in  DATA_W  signed parameter word
burst_start  in  1  one-cycle pulse: start a burst at wr_addr
burst_len  in  ADDR_W  number of words in the burst, sampled with burst_start; 0 is treated as 1
commit  in  1  one-cycle pulse: shadow bank -> active outputs
lines_flat  out  N_CH*DATA_W  active channels; channel k occupies bits [k*DATA_W +: DATA_W]
all_loaded  out  1  every channel written since the last commit or reset
addr_err  out  1  sticky: an out-of-range write was dropped
commit_done  out  1  one-cycle pulse on the cycle after the active bank updates

Behaviour:
- Reset (rst=1 at a clock edge):
  - Shadow bank, active bank, written mask, stage register, burst counter and commit_pend all clear; state=IDLE.
  - Outputs: lines_flat=0, all_loaded=0, addr_err=0, commit_done=0, wr_ready=0 during reset.
  - Reset mid-burst or mid-commit aborts the operation with no partial commit.
- States: IDLE, BURST, COMMIT.
  - wr_ready=1 in IDLE and BURST.
  - wr_ready=0 in COMMIT and while rst=1.
- Handshake: a word transfers when wr_valid & wr_ready at a rising edge.
- Write pipeline, handshake in cycle N:
  - Edge ending cycle N: {addr, data} captured into the stage register, stage_vld=1.
  - Edge ending cycle N+1: shadow[addr-BASE_ADDR] written and its written-mask bit set.
  - Back-to-back writes give 1 word per cycle.
  - A write to the same address as the word in the stage register is legal; the later word wins.
- Address check at the shadow write:
  - If addr<BASE_ADDR or addr>=BASE_ADDR+N_CH, the write is dropped and addr_err is set.
  - addr_err is cleared only by rst.
- Single write (IDLE, burst_start=0): the word goes to wr_addr.
- Burst:
  - burst_start in IDLE loads ptr=wr_addr and cnt=max(burst_len,1), then state goes to BURST.
  - If wr_valid is also high that cycle, that word is the first burst word and goes to wr_addr.
  - Each accepted word in BURST goes to ptr; then ptr increments and cnt decrements.
  - Wrap-around: ptr=BASE_ADDR+N_CH-1 increments to BASE_ADDR.
  - When cnt reaches 0 the state returns to IDLE.
  - burst_start while in BURST is ignored.
  - A start address out of range produces dropped words and addr_err until ptr wraps into range.
- Commit:
  - commit in IDLE goes to COMMIT.
  - commit in BURST sets commit_pend; COMMIT is entered the cycle after the burst completes.
  - In COMMIT the block waits until stage_vld=0 (at most 1 cycle), then copies active<=shadow in one edge and clears the written mask.
  - commit_done pulses the next cycle; the state returns to IDLE.
  - The shadow bank keeps its contents after a commit.
  - commit simultaneous with an accepted single write: the write is accepted and lands in shadow before the copy.
- all_loaded = AND of the written mask, registered; it updates the cycle after the final shadow write.
- Arithmetic: all address compares and increments are unsigned, ADDR_W bits; data is passed through unmodified.

Test Plan:
1. rst 2 cycles -> lines_flat=0, all_loaded=0, addr_err=0, wr_ready=0 during reset and 1 after.
2. Single writes: addr 1 data 0x00000011, addr 24 data 0xFFFFFFF0, then commit -> channel 0=0x11, channel 23=-16, others 0; commit_done pulses exactly once; lines_flat unchanged before commit.
3. Burst: start addr 20, len 8, data 100..107 back-to-back -> channels 19..23=100..104 and channels 0..2=105..107 after wrap; state back to IDLE after 8 transfers; no addr_err.
4. 24-word burst from addr 1 -> all_loaded=1 one cycle after the last shadow write; commit -> all_loaded=0 and active bank equals the data.
5. Writes to addr 0 and addr 25 -> addr_err=1 sticky, shadow unchanged; a subsequent valid write still lands.
6. commit asserted mid-burst (after 3 of 6 words) -> the remaining 3 words are accepted and the copy occurs after word 6; rst asserted in the COMMIT cycle -> all outputs 0, no commit_done.
